// File: rtl/inst_encoder_loader_pkg.sv
// Shared types and constants for the instruction encoder/loader.
// The field layout matches the one the ID-stage control unit decodes.
package inst_encoder_loader_pkg;

   typedef enum logic [1:0] {
      CLASS_DP  = 2'b00,
      CLASS_MEM = 2'b01,
      CLASS_BR  = 2'b10,
      CLASS_ILL = 2'b11
   } inst_class_e;

   localparam logic [1:0] MODE_DP  = 2'b00;
   localparam logic [1:0] MODE_MEM = 2'b01;
   localparam logic [1:0] MODE_BR  = 2'b10;

   localparam logic [3:0] OP_AND     = 4'b0000;
   localparam logic [3:0] OP_EOR     = 4'b0001;
   localparam logic [3:0] OP_SUB     = 4'b0010;
   localparam logic [3:0] OP_ADD     = 4'b0100;
   localparam logic [3:0] OP_ADC     = 4'b0101;
   localparam logic [3:0] OP_SBC     = 4'b0110;
   localparam logic [3:0] OP_TST     = 4'b1000;
   localparam logic [3:0] OP_CMP     = 4'b1010;
   localparam logic [3:0] OP_ORR     = 4'b1100;
   localparam logic [3:0] OP_MOV     = 4'b1101;
   localparam logic [3:0] OP_MVN     = 4'b1111;
   localparam logic [3:0] OP_LDR_STR = 4'b0100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FULL = 2'b10
   } state_e;

endpackage

// File: rtl/inst_encoder_loader_field_packer.sv
// Combinational packing of one decoded field bundle into a 32-bit word,
// plus a flag for the illegal class (which produces no word).
module inst_field_packer
   import inst_encoder_loader_pkg::*;
(
   input  inst_class_e  cls,
   input  logic [3:0]   opcode,
   input  logic         s,
   input  logic [3:0]   cond,
   input  logic         imm,
   input  logic [3:0]   rn,
   input  logic [3:0]   rd,
   input  logic [11:0]  shop,
   input  logic [23:0]  boff,
   output logic [31:0]  word,
   output logic         illegal
);

   logic       cmp_like;
   logic       mov_like;
   logic       dp_s;
   logic [3:0] dp_rn;
   logic [3:0] dp_rd;

   // Compare/test ops always set flags and have no destination; moves have no first operand.
   assign cmp_like = (opcode == OP_CMP) || (opcode == OP_TST);
   assign mov_like = (opcode == OP_MOV) || (opcode == OP_MVN);
   assign dp_s     = cmp_like ? 1'b1 : s;
   assign dp_rd    = cmp_like ? 4'd0 : rd;
   assign dp_rn    = mov_like ? 4'd0 : rn;

   always_comb begin
      // NOTE: both outputs get a default before the case so no path can infer a latch.
      word    = '0;
      illegal = 1'b0;
      case (cls)
         CLASS_DP:  word = {cond, MODE_DP, imm, opcode, dp_s, dp_rn, dp_rd, shop};
         CLASS_MEM: word = {cond, MODE_MEM, 1'b0, OP_LDR_STR, s, rn, rd, shop};
         CLASS_BR:  word = {cond, MODE_BR, 1'b1, 1'b0, boff};
         default:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/inst_encoder_loader.sv
// Loads encoded instruction words sequentially into instruction memory:
// FSM, output write register, address counter and word count.
module inst_encoder_loader
   import inst_encoder_loader_pkg::*;
#(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          ADDR_W    = 32,
   localparam int         CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_class,
   input  logic [3:0]        in_opcode,
   input  logic              in_s,
   input  logic [3:0]        in_cond,
   input  logic              in_imm,
   input  logic [3:0]        in_rn,
   input  logic [3:0]        in_rd,
   input  logic [11:0]       in_shop,
   input  logic [23:0]       in_boff,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [CNT_W-1:0]  count,
   output logic              busy,
   output logic              full,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
   localparam logic [CNT_W-1:0]  LAST      = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       packed_word;
   logic              packed_illegal;
   logic              accept;

   inst_field_packer u_packer (
      .cls     (inst_class_e'(in_class)),
      .opcode  (in_opcode),
      .s       (in_s),
      .cond    (in_cond),
      .imm     (in_imm),
      .rn      (in_rn),
      .rd      (in_rd),
      .shop    (in_shop),
      .boff    (in_boff),
      .word    (packed_word),
      .illegal (packed_illegal)
   );

   // A start pulse wins over any bundle offered in RUN, so nothing is accepted then dropped.
   assign in_ready = (state_q == ST_RUN) && !start;
   assign accept   = in_valid && in_ready;

   // NOTE: there is no memory array here, so every register including the address is reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= BASE;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         count     <= '0;
         busy      <= 1'b0;
         full      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so later lines below override these pulse defaults.
         mem_we <= 1'b0;
         done   <= 1'b0;
         if (start) begin
            state_q <= ST_RUN;
            addr_q  <= BASE;
            count   <= '0;
            err     <= 1'b0;
            busy    <= 1'b1;
            full    <= 1'b0;
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (accept) begin
                     if (packed_illegal) begin
                        err <= 1'b1;
                     end else begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= packed_word;
                        addr_q    <= addr_q + WORD_STEP;
                        count     <= count + CNT_ONE;
                        if (count == LAST) begin
                           state_q <= ST_FULL;
                           full    <= 1'b1;
                        end
                     end
                  end
                  if (finish) begin
                     state_q <= ST_IDLE;
                     busy    <= 1'b0;
                     full    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
               ST_FULL: begin
                  if (finish) begin
                     state_q <= ST_IDLE;
                     busy    <= 1'b0;
                     full    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Randomized bench for inst_encoder_loader against a behavioural load model,
// with directed cases whose literal words pin the model's encoder.
module tb_inst_encoder_loader;

   localparam int          DEPTH  = 4;
   localparam int          ADDR_W = 32;
   localparam int          CNT_W  = $clog2(DEPTH) + 1;
   localparam logic [31:0] BASE   = 32'h0000_0000;

   typedef struct packed {
      logic [1:0]  cls;
      logic [3:0]  op;
      logic        s;
      logic [3:0]  cond;
      logic        imm;
      logic [3:0]  rn;
      logic [3:0]  rd;
      logic [11:0] shop;
      logic [23:0] boff;
   } bundle_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              finish = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [1:0]        in_class = '0;
   logic [3:0]        in_opcode = '0;
   logic              in_s = 1'b0;
   logic [3:0]        in_cond = '0;
   logic              in_imm = 1'b0;
   logic [3:0]        in_rn = '0;
   logic [3:0]        in_rd = '0;
   logic [11:0]       in_shop = '0;
   logic [23:0]       in_boff = '0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [CNT_W-1:0]  count;
   logic              busy, full, done, err;

   int n_checks = 0;
   int n_errors = 0;
   int wr_cnt   = 0;

   // Behavioural model: a load is active or not, holds a number of words written and a sticky error.
   bit          m_active = 0;
   int          m_cnt    = 0;
   bit          m_err    = 0;
   bit          e_we     = 0;
   bit          e_done   = 0;
   logic [31:0] e_addr   = '0;
   logic [31:0] e_wdata  = '0;

   inst_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
      .in_opcode(in_opcode), .in_s(in_s), .in_cond(in_cond), .in_imm(in_imm),
      .in_rn(in_rn), .in_rd(in_rd), .in_shop(in_shop), .in_boff(in_boff),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .count(count), .busy(busy), .full(full), .done(done), .err(err)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] encode(input bundle_t b);
      logic [31:0] w;
      logic [3:0]  rn, rd;
      logic        s;
      rn = b.rn; rd = b.rd; s = b.s;
      case (b.cls)
         2'd0: begin
            if (b.op == 4'd10 || b.op == 4'd8) begin s = 1'b1; rd = 4'd0; end
            if (b.op == 4'd13 || b.op == 4'd15) rn = 4'd0;
            w = (32'(b.cond) << 28) + (32'(b.imm) << 25) + (32'(b.op) << 21) + (32'(s) << 20)
              + (32'(rn) << 16) + (32'(rd) << 12) + 32'(b.shop);
         end
         2'd1: w = (32'(b.cond) << 28) + (32'd1 << 26) + (32'd4 << 21) + (32'(s) << 20)
                 + (32'(rn) << 16) + (32'(rd) << 12) + 32'(b.shop);
         2'd2: w = (32'(b.cond) << 28) + (32'd5 << 25) + 32'(b.boff);
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   function automatic void model_reset();
      m_active = 0; m_cnt = 0; m_err = 0;
      e_we = 0; e_done = 0; e_addr = '0; e_wdata = '0;
   endfunction

   function automatic void model_edge(input bit st, input bit fin, input bit v, input bundle_t b);
      bit ready;
      if (rst) begin
         model_reset();
         return;
      end
      ready  = m_active && (m_cnt < DEPTH) && !st;
      e_we   = 0;
      e_done = 0;
      if (st) begin
         m_active = 1; m_cnt = 0; m_err = 0;
      end else if (m_active) begin
         if (v && ready) begin
            if (b.cls == 2'd3) m_err = 1;
            else begin
               e_we    = 1;
               e_addr  = BASE + 32'(4 * m_cnt);
               e_wdata = encode(b);
               m_cnt++;
            end
         end
         if (fin) begin
            m_active = 0;
            e_done   = 1;
         end
      end
   endfunction

   // Single compare process: every registered output plus in_ready against the model.
   always @(negedge clk) begin
      if (mem_we) wr_cnt++;
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
      check("count", 32'(count), 32'(m_cnt));
      check("busy", 32'(busy), 32'(m_active));
      check("full", 32'(full), 32'(m_active && m_cnt == DEPTH));
      check("done", 32'(done), 32'(e_done));
      check("err", 32'(err), 32'(m_err));
      check("in_ready", 32'(in_ready), 32'(!rst && m_active && m_cnt < DEPTH && !start));
   end

   task automatic step(input bit st, input bit fin, input bit v, input bundle_t b);
      start = st; finish = fin; in_valid = v;
      in_class = b.cls; in_opcode = b.op; in_s = b.s; in_cond = b.cond; in_imm = b.imm;
      in_rn = b.rn; in_rd = b.rd; in_shop = b.shop; in_boff = b.boff;
      @(posedge clk);
      model_edge(st, fin, v, b);
      #1;
   endtask

   function automatic bundle_t mk(input logic [1:0] cls, input logic [3:0] op, input logic s,
                                  input logic imm, input logic [3:0] rn, input logic [3:0] rd,
                                  input logic [11:0] shop, input logic [23:0] boff);
      bundle_t b;
      b.cls = cls; b.op = op; b.s = s; b.cond = 4'hE; b.imm = imm;
      b.rn = rn; b.rd = rd; b.shop = shop; b.boff = boff;
      return b;
   endfunction

   function automatic bundle_t rand_bundle();
      bundle_t b;
      b      = bundle_t'({$urandom, $urandom, $urandom});
      b.cls  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      return b;
   endfunction

   initial begin
      bundle_t nop, add_b, ldr_b, str_b, br_b, cmp_b, ill_b;
      int      w0;
      bit      st, fin, v;
      nop   = '0;
      add_b = mk(2'd0, 4'b0100, 1'b0, 1'b1, 4'd1, 4'd2, 12'h005, 24'h0);
      ldr_b = mk(2'd1, 4'b0000, 1'b1, 1'b0, 4'd3, 4'd4, 12'h008, 24'h0);
      str_b = mk(2'd1, 4'b0000, 1'b0, 1'b0, 4'd3, 4'd4, 12'h008, 24'h0);
      br_b  = mk(2'd2, 4'b0000, 1'b0, 1'b0, 4'd0, 4'd0, 12'h000, 24'hFFFFFE);
      cmp_b = mk(2'd0, 4'b1010, 1'b0, 1'b0, 4'd5, 4'd7, 12'h001, 24'h0);
      ill_b = mk(2'd3, 4'b0100, 1'b0, 1'b0, 4'd1, 4'd2, 12'h005, 24'h0);

      // Pin the model's encoder with hand-computed words.
      check("enc_add", encode(add_b), 32'hE2812005);
      check("enc_ldr", encode(ldr_b), 32'hE4934008);
      check("enc_str", encode(str_b), 32'hE4834008);
      check("enc_br", encode(br_b), 32'hEAFFFFFE);

      repeat (3) step(0, 0, 0, nop);
      rst = 1'b0;
      step(0, 0, 0, nop);

      // start from IDLE with a bundle offered: not accepted.
      step(1, 0, 1, add_b);
      step(0, 0, 0, nop);
      check("idle_no_write", 32'(wr_cnt), 32'd0);
      step(0, 0, 1, add_b);
      check("add_we", 32'(mem_we), 32'd1);
      check("add_addr", mem_addr, 32'h0);
      check("add_word", mem_wdata, 32'hE2812005);

      step(1, 0, 0, nop);
      step(0, 0, 1, ldr_b);
      check("ldr_word", mem_wdata, 32'hE4934008);
      check("ldr_addr", mem_addr, 32'h0);
      step(0, 0, 1, str_b);
      check("str_word", mem_wdata, 32'hE4834008);
      check("str_addr", mem_addr, 32'h4);
      step(0, 0, 1, br_b);
      check("br_word", mem_wdata, 32'hEAFFFFFE);
      step(0, 0, 1, cmp_b);
      check("cmp_s", 32'(mem_wdata[20]), 32'd1);
      check("cmp_rd", 32'(mem_wdata[15:12]), 32'd0);
      check("cmp_full", 32'(full), 32'd1);

      // Six back-to-back bundles into a fresh load of DEPTH words.
      step(1, 0, 0, nop);
      w0 = wr_cnt;
      repeat (6) step(0, 0, 1, add_b);
      step(0, 0, 0, nop);
      check("full_writes", 32'(wr_cnt - w0), 32'(DEPTH));
      check("full_flag", 32'(full), 32'd1);
      check("full_ready", 32'(in_ready), 32'd0);
      check("full_count", 32'(count), 32'(DEPTH));

      // Illegal bundle then ADD; err holds past finish until the next start.
      step(1, 0, 0, nop);
      w0 = wr_cnt;
      step(0, 0, 1, ill_b);
      step(0, 0, 1, add_b);
      check("ill_err", 32'(err), 32'd1);
      check("ill_add_addr", mem_addr, 32'h0);
      step(0, 1, 0, nop);
      check("done_pulse", 32'(done), 32'd1);
      step(0, 0, 0, nop);
      check("done_once", 32'(done), 32'd0);
      check("err_hold", 32'(err), 32'd1);
      step(0, 0, 0, nop);
      check("ill_writes", 32'(wr_cnt - w0), 32'd1);
      step(1, 0, 0, nop);
      check("err_clear", 32'(err), 32'd0);

      // Reset mid-run with a bundle on the input.
      step(0, 0, 1, add_b);
      in_valid = 1'b1;
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      w0 = wr_cnt;
      repeat (2) step(0, 0, 1, add_b);
      rst = 1'b0;
      repeat (3) step(0, 0, 1, add_b);
      check("rst_no_write", 32'(wr_cnt - w0), 32'd0);

      // Randomized loads.
      for (int i = 0; i < 3000; i++) begin
         st  = ($urandom_range(0, 39) == 0);
         fin = !st && ($urandom_range(0, 29) == 0);
         v   = !st && !fin && ($urandom_range(0, 3) != 0);
         step(st, fin, v, rand_bundle());
      end
      step(0, 0, 0, nop);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Encoder counterpart to the ID-stage control unit.
- Accepts decoded instruction fields (class, opcode, S, cond, registers, operand) over a valid/ready handshake.
- Packs them into 32-bit ARM-subset instruction words using the same field layout the control unit decodes.
- Writes the words sequentially into instruction memory, so self-test and boot programs can be loaded into the IF stage without an external assembler.

Parameters:
- DEPTH, 64: instruction memory capacity in words.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written.
- ADDR_W, 32: width of the memory address port.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; rewinds to BASE_ADDR and begins a load.
- finish  in  1  one-cycle pulse; ends the load.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- in_class  in  2  00 data-processing, 01 memory, 10 branch, 11 illegal.
- in_opcode  in  4  data-processing opcode; ignored for other classes.
- in_s  in  1  S bit for data-processing; for memory, 1 = LDR and 0 = STR.
- in_cond  in  4  condition field.
- in_imm  in  1  I bit; data-processing only.
- in_rn  in  4  Rn.
- in_rd  in  4  Rd.
- in_shop  in  12  shifter operand, or memory offset12.
- in_boff  in  24  signed branch word offset.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  32  encoded word.
- count  out  $clog2(DEPTH)+1  words written in the current load.
- busy  out  1  state is RUN or FULL.
- full  out  1  DEPTH words written.
- done  out  1  one-cycle pulse when a load ends.
- err  out  1  sticky; an illegal-class bundle was received.

Behaviour:
- Reset values: every output is 0; state IDLE; address register = BASE_ADDR.
- States: IDLE, RUN, FULL.
  - IDLE: in_ready = 0. start -> RUN; clears count and err; address = BASE_ADDR.
  - RUN: in_ready = 1.
    - A bundle is accepted on in_valid & in_ready.
    - Exactly one cycle later: mem_we = 1, mem_wdata = encoded word, mem_addr = current address.
    - In that same cycle the address increments by 4 and count increments by 1.
    - When count reaches DEPTH -> FULL.
  - FULL: in_ready = 0, full = 1.
- finish in RUN or FULL:
  - Returns to IDLE and pulses done the next cycle.
  - A write already in flight from the previous accept still completes.
- start in RUN or FULL restarts the load. start has priority over finish in the same cycle.
- A bundle presented in the same cycle as start is not accepted, because in_ready is 0 in IDLE.
- Acceptance while count = DEPTH-1: the write completes, then FULL is entered. No write is ever issued at count ≥ DEPTH.
- Encoding, common fields: [31:28] = cond.
- Class 00 (data-processing):
  - [27:26] = 00, [25] = imm, [24:21] = opcode, [20] = S, [19:16] = Rn, [15:12] = Rd, [11:0] = shop.
  - CMP (1010) and TST (1000): S is forced to 1 and Rd to 0.
  - MOV (1101) and MVN (1111): Rn is forced to 0.
  - Any other opcode is passed through unchanged.
- Class 01 (memory):
  - [27:26] = 01, [25] = 0, [24:21] = 0100, [20] = in_s, [19:16] = Rn, [15:12] = Rd, [11:0] = shop.
- Class 10 (branch):
  - [27:25] = 101, [24] = 0, [23:0] = boff.
- Class 11 (illegal): the bundle is accepted but no write is issued; err sets and holds until the next start or rst.
- rst mid-load: state is aborted immediately; no further mem_we; done is not pulsed.
- Latency: one cycle from accept to write. Throughput: one word per cycle.

Decomposition:
- Shared package holds:
  - class codes.
  - mode constants MODE_DP = 00, MODE_MEM = 01, MODE_BR = 10.
  - opcode constants: MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR, CMP, TST, plus the LDR/STR opcode 0100.
  - the state enum.
- Sub-module inst_field_packer: purely combinational bundle-to-word packing plus an illegal flag. The top level holds the FSM, the output register, the address counter and count.

Test Plan:
- start, then ADD (cond E, op 0100, S 0, I 1, Rn 1, Rd 2, shop 0x005) -> next cycle mem_we = 1, addr 0x0, wdata 0xE2812005.
- LDR (cond E, Rn 3, Rd 4, off 0x008), then STR with the same fields -> wdata 0xE4934008 at addr 0x0, then 0xE4834008 at addr 0x4.
- Branch (cond E, boff 0xFFFFFE) -> 0xEAFFFFFE. CMP with S = 0 and Rd = 7 -> bit 20 = 1 and Rd field = 0.
- DEPTH = 4 with 6 back-to-back bundles -> exactly 4 writes at 0x0–0xC; full = 1; in_ready = 0.
- Illegal class, then ADD -> no write for the illegal bundle, err = 1, ADD written at 0x0. finish -> done pulses once; err holds until the next start.
- rst asserted mid-run while in_valid = 1 -> all outputs 0 immediately; no mem_we follows.
